// File: rtl/alu_pkg.sv
// Shared constants for the ALU frame sequencer: data width, opcodes, FSM state encoding.
package alu_pkg;

  localparam int unsigned DATA_W = 8;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_NAND = 3'd5;
  localparam logic [2:0] OP_NOR  = 3'd6;
  localparam logic [2:0] OP_NOT  = 3'd7;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_GET_A = 3'd1;
  localparam logic [2:0] ST_GET_B = 3'd2;
  localparam logic [2:0] ST_EXEC  = 3'd3;
  localparam logic [2:0] ST_RESP  = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_GET_A = ST_GET_A,
    S_GET_B = ST_GET_B,
    S_EXEC  = ST_EXEC,
    S_RESP  = ST_RESP
  } state_e;

endpackage

// File: rtl/alu_core_8bit.sv
// Purely combinational 8-bit ALU; carry is the add carry-out or the subtract borrow.
module alu_core_8bit
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [2:0]        op,
  output logic [DATA_W-1:0] result,
  output logic              carry
);

  logic [DATA_W:0] sum;
  logic [DATA_W:0] diff;

  // Widened by one bit so the MSB is the carry-out / borrow.
  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    result = '0;
    carry  = 1'b0;
    case (op)
      OP_ADD:  begin result = sum[DATA_W-1:0];  carry = sum[DATA_W];  end
      OP_SUB:  begin result = diff[DATA_W-1:0]; carry = diff[DATA_W]; end
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_NAND: result = ~(a & b);
      OP_NOR:  result = ~(a | b);
      OP_NOT:  result = ~a;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_frame_sequencer.sv
// Collects opcode/A/B byte frames on one 8-bit valid/ready bus, runs the ALU and
// returns a registered result with zero/carry flags on a valid/ready output.
module alu_frame_sequencer
  import alu_pkg::*;
#(
  parameter bit CHECK_OPCODE = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_zero,
  output logic              out_carry,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              err
);

  state_e            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_zero_q, out_zero_d;
  logic              out_carry_q, out_carry_d;
  logic              out_valid_q, out_valid_d;
  logic              err_q, err_d;

  logic [DATA_W-1:0] alu_result;
  logic              alu_carry;
  logic              in_fire;
  logic              bad_opcode;

  alu_core_8bit u_alu_core (
    .a      (a_q),
    .b      (b_q),
    .op     (op_q),
    .result (alu_result),
    .carry  (alu_carry)
  );

  assign in_ready   = (state_q == S_IDLE) || (state_q == S_GET_A) || (state_q == S_GET_B);
  assign in_fire    = in_valid && in_ready;
  assign bad_opcode = CHECK_OPCODE && (|in_data[DATA_W-1:3]);

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    out_data_d  = out_data_q;
    out_zero_d  = out_zero_q;
    out_carry_d = out_carry_q;
    out_valid_d = out_valid_q;
    err_d       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_fire) begin
          if (bad_opcode) begin
            err_d = 1'b1;
          end else begin
            op_d    = in_data[2:0];
            state_d = S_GET_A;
          end
        end
      end
      S_GET_A: begin
        if (in_fire) begin
          a_d     = in_data;
          state_d = S_GET_B;
        end
      end
      S_GET_B: begin
        if (in_fire) begin
          b_d     = in_data;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        out_data_d  = alu_result;
        out_zero_d  = (alu_result == '0);
        out_carry_d = alu_carry;
        out_valid_d = 1'b1;
        state_d     = S_RESP;
      end
      S_RESP: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      out_data_q  <= '0;
      out_zero_q  <= 1'b0;
      out_carry_q <= 1'b0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      out_data_q  <= out_data_d;
      out_zero_q  <= out_zero_d;
      out_carry_q <= out_carry_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_zero  = out_zero_q;
  assign out_carry = out_carry_q;
  assign out_valid = out_valid_q;
  assign err       = err_q;

endmodule

// File: tb/tb_alu_frame_sequencer.sv
// Scoreboard bench for alu_frame_sequencer: frames are driven byte by byte, expected
// results are queued at stimulus time and compared when out_valid appears.
module tb_alu_frame_sequencer;

  typedef struct packed {
    logic [7:0] d;
    logic       z;
    logic       c;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_zero;
  logic       out_carry;
  logic       out_valid;
  logic       out_ready;
  logic       err;

  int   n_checks;
  int   n_fail;
  exp_t sb[$];

  alu_frame_sequencer #(.CHECK_OPCODE(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_zero  (out_zero),
    .out_carry (out_carry),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Reference behaviour of the ALU, written from the opcode table.
  function automatic exp_t model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    logic [8:0] s;
    e.c = 1'b0;
    case (op)
      3'd0: begin s = 9'(a) + 9'(b); e.d = s[7:0]; e.c = s[8]; end
      3'd1: begin e.d = a - b; e.c = (a < b); end
      3'd2: e.d = a & b;
      3'd3: e.d = a | b;
      3'd4: e.d = a ^ b;
      3'd5: e.d = ~(a & b);
      3'd6: e.d = ~(a | b);
      default: e.d = ~a;
    endcase
    e.z = (e.d == 8'h00);
    return e;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    int cnt;
    cnt      = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && cnt < 50) begin
      @(posedge clk); #1;
      cnt++;
    end
    if (cnt >= 50) chk("in_ready_timeout", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic run_frame(input logic [7:0] opb, input logic [7:0] a, input logic [7:0] b,
                           input bit hold);
    exp_t e;
    sb.push_back(model(opb[2:0], a, b));
    out_ready = !hold;
    send_byte(opb);
    send_byte(a);
    send_byte(b);
    chk("exec_no_valid", 32'(out_valid), 32'd0);
    chk("exec_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    chk("latency_valid", 32'(out_valid), 32'd1);
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk("out_data", 32'(out_data), 32'(e.d));
      chk("out_zero", 32'(out_zero), 32'(e.z));
      chk("out_carry", 32'(out_carry), 32'(e.c));
      if (hold) begin
        for (int i = 0; i < 5; i++) begin
          @(posedge clk); #1;
          chk("bp_valid", 32'(out_valid), 32'd1);
          chk("bp_data", 32'({out_data, out_zero, out_carry}), 32'({e.d, e.z, e.c}));
          chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
      end
    end
    @(posedge clk); #1;
    chk("done_valid", 32'(out_valid), 32'd0);
    chk("done_idle", 32'(in_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    in_data   = 8'h00;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_outs", 32'({out_data, out_zero, out_carry, err}), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_frame(8'h00, 8'h0F, 8'h01, 1'b0);
    run_frame(8'h00, 8'hFF, 8'h01, 1'b0);
    run_frame(8'h01, 8'h05, 8'h07, 1'b0);
    run_frame(8'h05, 8'hF0, 8'h0F, 1'b0);

    // Rejected opcode: single pulse, stays in IDLE.
    in_data  = 8'h09;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("err_pulse", 32'(err), 32'd1);
    chk("err_idle", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    chk("err_clear", 32'(err), 32'd0);

    // Back-to-back rejected opcodes.
    in_data  = 8'hF8;
    in_valid = 1'b1;
    @(posedge clk); #1;
    chk("err_b2b_0", 32'(err), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("err_b2b_1", 32'(err), 32'd1);
    @(posedge clk); #1;
    chk("err_b2b_clr", 32'(err), 32'd0);

    run_frame(8'h03, 8'hA0, 8'h05, 1'b0);
    run_frame(8'h04, 8'h3C, 8'h5A, 1'b1);

    // Reset in the middle of a frame.
    send_byte(8'h00);
    send_byte(8'h12);
    rst = 1'b1;
    #1;
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_outs", 32'({out_data, out_zero, out_carry, err}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_frame(8'h07, 8'h3C, 8'h00, 1'b0);

    for (int i = 0; i < 8; i++) begin
      run_frame({5'b0, 3'($urandom_range(0, 7))}, 8'($urandom), 8'($urandom), ($urandom_range(0, 3) == 0));
    end
    run_frame(8'h01, 8'h40, 8'h40, 1'b0);
    run_frame(8'h06, 8'hFF, 8'h00, 1'b0);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
